multi_cycle_control: RTL and testbench
======================================

// Module: multi_cycle_control
// PURPOSE
//  Multi-cycle sequencer for the LEGv8 datapath. Same instruction subset as the single-cycle decoder:
//  AND/ORR/ADD/SUB reg, ADDI/SUBI, MOVZ, B, CBZ, LDUR, STUR.
//  Steps one instruction at a time through FETCH/DECODE/EXEC/MEM/WB so the ALU and one memory port are shared.
//  Stalls on instruction/data memory ready and counts retired instructions.
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter
// PORTS
//  CLK           in   1      clock, rising edge
//  Reset         in   1      asynchronous, active-high reset
//  run           in   1      1 = execute; sampled only at instruction boundary (IDLE/FETCH entry)
//  imem_ready    in   1      instruction word valid this cycle (FETCH)
//  opcode        in   11     instr[31:21], valid when imem_ready=1 in FETCH
//  mem_ready     in   1      data memory access complete this cycle (MEM)
//  zero          in   1      ALU zero flag, valid in EXEC
//  ir_write      out  1      latch instruction register and old_pc
//  pc_write      out  1      update PC
//  pc_src        out  1      0 = PC+4, 1 = branch target (old_pc + offset)
//  reg2loc, alusrc, mem2reg, regwrite, memread, memwrite   out 1 each   datapath strobes
//  aluop         out  4      0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 PASSB
//  signop        out  2      00 I-type, 01 D-type, 10 B-type, 11 CB-type (MOVZ uses 00)
//  busy          out  1      1 in any state except IDLE and TRAP
//  illegal       out  1      sticky: unsupported opcode fetched
//  retired       out  CNT_W  instructions completed since reset
// BEHAVIOUR
//  Reset: state=IDLE, op_q=0, retired=0, illegal=0; all strobes 0, aluop=0000, signop=00. Reset mid-op aborts with no writes.
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are Moore: f(state, op_q); never X.
//  IDLE: run=1 -> FETCH.
//  FETCH: hold until imem_ready=1; that cycle ir_write=1, pc_write=1, pc_src=0, op_q<=opcode.
//    Unsupported opcode -> TRAP (illegal<=1, no writes); else -> DECODE.
//  DECODE: reg2loc=1 for CBZ/STUR else 0; signop per class. -> EXEC.
//  EXEC: aluop/alusrc per class (AND/ORR/ADD/SUB reg alusrc=0; ADDI/SUBI/MOVZ/LDUR/STUR alusrc=1; CBZ PASSB alusrc=0).
//    B: pc_write=1, pc_src=1, retire -> FETCH/IDLE.  CBZ: pc_write=zero, pc_src=1, retire -> FETCH/IDLE.
//    LDUR/STUR -> MEM; all others -> WB.
//  MEM: LDUR memread=1, STUR memwrite=1, held every cycle until mem_ready=1.
//    mem_ready: LDUR -> WB; STUR retires -> FETCH/IDLE.
//  WB: regwrite=1 for one cycle; mem2reg=1 only for LDUR; retire -> FETCH/IDLE.
//  Retire: retired += 1 (wraps modulo 2^CNT_W); next = run ? FETCH : IDLE.
//  Latency at ready=1: B/CBZ 3 cycles, R/I/MOVZ/STUR 4, LDUR 5.
//  Exactly one of regwrite/memwrite/pc_write(branch) per instruction; regwrite never in same cycle as memwrite.
//  run deasserted mid-instruction: current instruction completes, then IDLE.
//  TRAP: all strobes 0, busy=0; exit only via Reset.
// STRUCTURE
//  Package multi_cycle_pkg: opcode casez patterns, state enum, ALUOP_* and SIGNOP_* constants, instr_class enum.
//  Sub-module instr_class_decode: combinational opcode[10:0] -> instr_class (incl. CLS_ILLEGAL).
//  Top holds state register, op_q, retired counter, illegal flag, output decode.
// TESTING
//  ADD reg (opcode 10001011000), run=1, readies=1 -> FETCH,DECODE,EXEC(aluop=0010,alusrc=0),WB(regwrite=1); retired=1 after 4 cycles.
//  LDUR (11111000010) with mem_ready low 3 cycles -> memread=1 for 4 MEM cycles, then WB mem2reg=1 regwrite=1; total 8 cycles.
//  CBZ (10110100xxx) zero=1 -> EXEC pc_write=1 pc_src=1; zero=0 -> pc_write=0; both retire in 3 cycles.
//  STUR then run=0 -> memwrite=1 in MEM only, no regwrite; state IDLE after retire, busy=0.
//  Opcode 11111111111 -> TRAP, illegal=1, no strobes; run toggling ignored; Reset -> IDLE, illegal=0, retired=0.
//  Reset asserted mid-MEM of STUR -> memwrite drops immediately (async), state IDLE, retired unchanged at 0.

Source files
------------

// File: rtl/multi_cycle_pkg.sv
// Shared types and decode helpers for the LEGv8 multi-cycle sequencer.
// Opcode patterns live in classify() so both decoder instances stay consistent.
package multi_cycle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CLS_AND,
        CLS_ORR,
        CLS_ADD,
        CLS_SUB,
        CLS_ADDI,
        CLS_SUBI,
        CLS_MOVZ,
        CLS_B,
        CLS_CBZ,
        CLS_LDUR,
        CLS_STUR,
        CLS_ILLEGAL
    } instr_class_t;

    localparam logic [3:0] ALUOP_AND   = 4'b0000;
    localparam logic [3:0] ALUOP_ORR   = 4'b0001;
    localparam logic [3:0] ALUOP_ADD   = 4'b0010;
    localparam logic [3:0] ALUOP_SUB   = 4'b0110;
    localparam logic [3:0] ALUOP_PASSB = 4'b0111;

    localparam logic [1:0] SIGNOP_I  = 2'b00;
    localparam logic [1:0] SIGNOP_D  = 2'b01;
    localparam logic [1:0] SIGNOP_B  = 2'b10;
    localparam logic [1:0] SIGNOP_CB = 2'b11;

    function automatic instr_class_t classify(input logic [10:0] op);
        instr_class_t cls;
        casez (op)
            11'b10001010000: cls = CLS_AND;
            11'b10101010000: cls = CLS_ORR;
            11'b10001011000: cls = CLS_ADD;
            11'b11001011000: cls = CLS_SUB;
            11'b1001000100?: cls = CLS_ADDI;
            11'b1101000100?: cls = CLS_SUBI;
            11'b110100101??: cls = CLS_MOVZ;
            11'b000101?????: cls = CLS_B;
            11'b10110100???: cls = CLS_CBZ;
            11'b11111000010: cls = CLS_LDUR;
            11'b11111000000: cls = CLS_STUR;
            default:         cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    function automatic logic [3:0] class_aluop(input instr_class_t cls);
        logic [3:0] op;
        case (cls)
            CLS_ORR:                              op = ALUOP_ORR;
            CLS_ADD, CLS_ADDI, CLS_LDUR, CLS_STUR: op = ALUOP_ADD;
            CLS_SUB, CLS_SUBI:                    op = ALUOP_SUB;
            CLS_MOVZ, CLS_CBZ:                    op = ALUOP_PASSB;
            default:                              op = ALUOP_AND;
        endcase
        return op;
    endfunction

    function automatic logic class_alusrc(input instr_class_t cls);
        return (cls == CLS_ADDI) || (cls == CLS_SUBI) || (cls == CLS_MOVZ) ||
               (cls == CLS_LDUR) || (cls == CLS_STUR);
    endfunction

    function automatic logic [1:0] class_signop(input instr_class_t cls);
        logic [1:0] s;
        case (cls)
            CLS_LDUR, CLS_STUR: s = SIGNOP_D;
            CLS_B:              s = SIGNOP_B;
            CLS_CBZ:            s = SIGNOP_CB;
            default:            s = SIGNOP_I;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode-to-class decoder; unsupported encodings map to CLS_ILLEGAL.
module instr_class_decode
    import multi_cycle_pkg::*;
(
    input  logic [10:0]  opcode,
    output instr_class_t cls
);

    assign cls = classify(opcode);

endmodule

// File: rtl/multi_cycle_control.sv
// LEGv8 multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared ALU and memory port,
// with ready-based stalls, a sticky illegal-opcode trap and a retired-instruction counter.
module multi_cycle_control
    import multi_cycle_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             run,
    input  logic             imem_ready,
    input  logic [10:0]      opcode,
    input  logic             mem_ready,
    input  logic             zero,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg2loc,
    output logic             alusrc,
    output logic             mem2reg,
    output logic             regwrite,
    output logic             memread,
    output logic             memwrite,
    output logic [3:0]       aluop,
    output logic [1:0]       signop,
    output logic             busy,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q, state_d;
    logic [10:0]      op_q;
    instr_class_t     fetch_cls, op_cls;
    logic [CNT_W-1:0] retired_q;
    logic             illegal_q;
    logic             retire, set_illegal, load_op;

    // The incoming word is classified before it is latched so a bad opcode never reaches DECODE.
    instr_class_decode u_fetch_dec (.opcode(opcode), .cls(fetch_cls));
    instr_class_decode u_op_dec    (.opcode(op_q),   .cls(op_cls));

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_op)     op_q      <= opcode;
            if (retire)      retired_q <= retired_q + CNT_W'(1);
            if (set_illegal) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg2loc     = 1'b0;
        alusrc      = 1'b0;
        mem2reg     = 1'b0;
        regwrite    = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        aluop       = ALUOP_AND;
        signop      = SIGNOP_I;
        retire      = 1'b0;
        set_illegal = 1'b0;
        load_op     = 1'b0;

        // Register-select and immediate format stay stable for the rest of the instruction.
        if (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
            reg2loc = (op_cls == CLS_CBZ) || (op_cls == CLS_STUR);
            signop  = class_signop(op_cls);
        end

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    load_op = 1'b1;
                    if (fetch_cls == CLS_ILLEGAL) begin
                        set_illegal = 1'b1;
                        state_d     = ST_TRAP;
                    end else begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                aluop  = class_aluop(op_cls);
                alusrc = class_alusrc(op_cls);
                case (op_cls)
                    CLS_B: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                    end
                    CLS_CBZ: begin
                        pc_write = zero;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                    end
                    CLS_LDUR, CLS_STUR: state_d = ST_MEM;
                    default:            state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                memread  = (op_cls == CLS_LDUR);
                memwrite = (op_cls == CLS_STUR);
                if (mem_ready) begin
                    if (op_cls == CLS_LDUR) state_d = ST_WB;
                    else                    retire  = 1'b1;
                end
            end
            ST_WB: begin
                regwrite = 1'b1;
                mem2reg  = (op_cls == CLS_LDUR);
                retire   = 1'b1;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: state_d = ST_IDLE;
        endcase

        if (retire) state_d = run ? ST_FETCH : ST_IDLE;
    end

    assign busy    = (state_q != ST_IDLE) && (state_q != ST_TRAP);
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: walks each instruction class through its states
// and checks every strobe cycle by cycle against hand-derived values.
module tb_multi_cycle_control;

    logic        CLK, Reset, run, imem_ready, mem_ready, zero;
    logic [10:0] opcode;
    logic        ir_write, pc_write, pc_src, reg2loc, alusrc, mem2reg, regwrite, memread, memwrite;
    logic [3:0]  aluop;
    logic [1:0]  signop;
    logic        busy, illegal;
    logic [31:0] retired;
    logic [8:0]  strb;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_ret = 0;

    localparam logic [8:0] IRW  = 9'b100000000;
    localparam logic [8:0] PCW  = 9'b010000000;
    localparam logic [8:0] PCS  = 9'b001000000;
    localparam logic [8:0] R2L  = 9'b000100000;
    localparam logic [8:0] ASRC = 9'b000010000;
    localparam logic [8:0] M2R  = 9'b000001000;
    localparam logic [8:0] RW   = 9'b000000100;
    localparam logic [8:0] MR   = 9'b000000010;
    localparam logic [8:0] MW   = 9'b000000001;
    localparam logic [8:0] NONE = 9'b000000000;

    multi_cycle_control #(.CNT_W(32)) dut (
        .CLK(CLK), .Reset(Reset), .run(run), .imem_ready(imem_ready), .opcode(opcode),
        .mem_ready(mem_ready), .zero(zero), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg2loc(reg2loc), .alusrc(alusrc), .mem2reg(mem2reg),
        .regwrite(regwrite), .memread(memread), .memwrite(memwrite), .aluop(aluop),
        .signop(signop), .busy(busy), .illegal(illegal), .retired(retired)
    );

    assign strb = {ir_write, pc_write, pc_src, reg2loc, alusrc, mem2reg, regwrite, memread, memwrite};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic snap(input string tag, input logic [8:0] s, input logic [3:0] a,
                        input logic [1:0] g, input logic b);
        #1;
        chk({tag, "/strb"},   32'(strb),   32'(s));
        chk({tag, "/aluop"},  32'(aluop),  32'(a));
        chk({tag, "/signop"}, 32'(signop), 32'(g));
        chk({tag, "/busy"},   32'(busy),   32'(b));
    endtask

    // IDLE -> FETCH -> DECODE -> EXEC -> WB -> IDLE for register/immediate ALU ops.
    task automatic run_simple(input string tag, input logic [10:0] op, input logic [3:0] a,
                              input logic asrc);
        opcode = op; run = 1'b1; imem_ready = 1'b1; mem_ready = 1'b1;
        snap({tag, ".idle"}, NONE, 4'b0000, 2'b00, 1'b0);
        next(); snap({tag, ".fetch"}, IRW | PCW, 4'b0000, 2'b00, 1'b1);
        next(); snap({tag, ".decode"}, NONE, 4'b0000, 2'b00, 1'b1);
        next(); snap({tag, ".exec"}, asrc ? ASRC : NONE, a, 2'b00, 1'b1);
        next(); run = 1'b0; snap({tag, ".wb"}, RW, 4'b0000, 2'b00, 1'b1);
        exp_ret++;
        next(); snap({tag, ".done"}, NONE, 4'b0000, 2'b00, 1'b0);
        chk({tag, ".retired"}, retired, 32'(exp_ret));
    endtask

    initial begin
        Reset = 1'b1; run = 1'b0; imem_ready = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        opcode = 11'b0;
        next(); next();
        snap("reset", NONE, 4'b0000, 2'b00, 1'b0);
        chk("reset.retired", retired, 32'd0);
        chk("reset.illegal", 32'(illegal), 32'd0);
        Reset = 1'b0;

        // ADD reg: 4 cycles, regwrite only in WB
        next();
        run_simple("add", 11'b10001011000, 4'b0010, 1'b0);

        // LDUR with 3 stall cycles in MEM
        opcode = 11'b11111000010; run = 1'b1; imem_ready = 1'b1; mem_ready = 1'b0;
        snap("ldur.idle", NONE, 4'b0000, 2'b00, 1'b0);
        next(); snap("ldur.fetch", IRW | PCW, 4'b0000, 2'b00, 1'b1);
        next(); snap("ldur.decode", NONE, 4'b0000, 2'b01, 1'b1);
        next(); snap("ldur.exec", ASRC, 4'b0010, 2'b01, 1'b1);
        next(); snap("ldur.mem0", MR, 4'b0000, 2'b01, 1'b1);
        next(); snap("ldur.mem1", MR, 4'b0000, 2'b01, 1'b1);
        next(); snap("ldur.mem2", MR, 4'b0000, 2'b01, 1'b1);
        next(); mem_ready = 1'b1; snap("ldur.mem3", MR, 4'b0000, 2'b01, 1'b1);
        next(); run = 1'b0; snap("ldur.wb", RW | M2R, 4'b0000, 2'b01, 1'b1);
        chk("ldur.wb.retired", retired, 32'd1);
        exp_ret++;
        next(); snap("ldur.done", NONE, 4'b0000, 2'b00, 1'b0);
        chk("ldur.retired", retired, 32'(exp_ret));

        // CBZ taken then not taken, back to back
        opcode = 11'b10110100101; run = 1'b1; zero = 1'b1;
        snap("cbz.idle", NONE, 4'b0000, 2'b00, 1'b0);
        next(); snap("cbz1.fetch", IRW | PCW, 4'b0000, 2'b00, 1'b1);
        next(); snap("cbz1.decode", R2L, 4'b0000, 2'b11, 1'b1);
        next(); snap("cbz1.exec", PCW | PCS | R2L, 4'b0111, 2'b11, 1'b1);
        exp_ret++;
        next(); zero = 1'b0; snap("cbz2.fetch", IRW | PCW, 4'b0000, 2'b00, 1'b1);
        chk("cbz1.retired", retired, 32'(exp_ret));
        next(); snap("cbz2.decode", R2L, 4'b0000, 2'b11, 1'b1);
        next(); run = 1'b0; snap("cbz2.exec", PCS | R2L, 4'b0111, 2'b11, 1'b1);
        exp_ret++;
        next(); snap("cbz2.done", NONE, 4'b0000, 2'b00, 1'b0);
        chk("cbz2.retired", retired, 32'(exp_ret));

        // STUR with a fetch stall and run dropped mid-instruction
        opcode = 11'b11111000000; run = 1'b1; imem_ready = 1'b0; mem_ready = 1'b1;
        snap("stur.idle", NONE, 4'b0000, 2'b00, 1'b0);
        next(); snap("stur.fstall", NONE, 4'b0000, 2'b00, 1'b1);
        next(); imem_ready = 1'b1; run = 1'b0; snap("stur.fetch", IRW | PCW, 4'b0000, 2'b00, 1'b1);
        next(); snap("stur.decode", R2L, 4'b0000, 2'b01, 1'b1);
        next(); snap("stur.exec", ASRC | R2L, 4'b0010, 2'b01, 1'b1);
        next(); snap("stur.mem", MW | R2L, 4'b0000, 2'b01, 1'b1);
        exp_ret++;
        next(); snap("stur.done", NONE, 4'b0000, 2'b00, 1'b0);
        chk("stur.retired", retired, 32'(exp_ret));

        // Unconditional B
        opcode = 11'b00010100000; run = 1'b1;
        snap("b.idle", NONE, 4'b0000, 2'b00, 1'b0);
        next(); snap("b.fetch", IRW | PCW, 4'b0000, 2'b00, 1'b1);
        next(); snap("b.decode", NONE, 4'b0000, 2'b10, 1'b1);
        next(); run = 1'b0; snap("b.exec", PCW | PCS, 4'b0000, 2'b10, 1'b1);
        exp_ret++;
        next(); snap("b.done", NONE, 4'b0000, 2'b00, 1'b0);
        chk("b.retired", retired, 32'(exp_ret));

        run_simple("and",  11'b10001010000, 4'b0000, 1'b0);
        run_simple("orr",  11'b10101010000, 4'b0001, 1'b0);
        run_simple("sub",  11'b11001011000, 4'b0110, 1'b0);
        run_simple("addi", 11'b10010001001, 4'b0010, 1'b1);
        run_simple("subi", 11'b11010001000, 4'b0110, 1'b1);
        run_simple("movz", 11'b11010010111, 4'b0111, 1'b1);

        // Illegal opcode traps with no writes; only Reset recovers
        opcode = 11'b11111111111; run = 1'b1;
        snap("ill.idle", NONE, 4'b0000, 2'b00, 1'b0);
        next(); snap("ill.fetch", NONE, 4'b0000, 2'b00, 1'b1);
        chk("ill.fetch.illegal", 32'(illegal), 32'd0);
        for (int i = 0; i < 3; i++) begin
            next(); run = i[0]; snap("ill.trap", NONE, 4'b0000, 2'b00, 1'b0);
            chk("ill.trap.illegal", 32'(illegal), 32'd1);
            chk("ill.trap.retired", retired, 32'(exp_ret));
        end
        Reset = 1'b1; #1;
        chk("ill.reset.illegal", 32'(illegal), 32'd0);
        chk("ill.reset.retired", retired, 32'd0);
        chk("ill.reset.busy", 32'(busy), 32'd0);
        next(); Reset = 1'b0;

        // Async reset in the middle of a STUR memory stall
        opcode = 11'b11111000000; run = 1'b1; mem_ready = 1'b0;
        snap("rst.idle", NONE, 4'b0000, 2'b00, 1'b0);
        next(); snap("rst.fetch", IRW | PCW, 4'b0000, 2'b00, 1'b1);
        next(); snap("rst.decode", R2L, 4'b0000, 2'b01, 1'b1);
        next(); snap("rst.exec", ASRC | R2L, 4'b0010, 2'b01, 1'b1);
        next(); snap("rst.mem", MW | R2L, 4'b0000, 2'b01, 1'b1);
        Reset = 1'b1; run = 1'b0;
        snap("rst.async", NONE, 4'b0000, 2'b00, 1'b0);
        chk("rst.async.memwrite", 32'(memwrite), 32'd0);
        chk("rst.async.retired", retired, 32'd0);
        next(); Reset = 1'b0;
        next(); snap("rst.after", NONE, 4'b0000, 2'b00, 1'b0);
        chk("rst.after.retired", retired, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
